// File: rtl/bop_multi_unit.sv
`default_nettype none
// ============================================================================
//  Module   : bop_multi_unit
//  Purpose  : Tracks runs of sequential stores, records qualifying runs as
//             address ranges, and raises alarms on suspicious loads from them.
//  Revision : 1.0 - initial release
// ============================================================================
module bop_multi_unit #(
   parameter int NUM_TRACKERS   = 4,
   parameter int RANGE_DEPTH    = 8,
   parameter int MIN_RUN        = 16,
   parameter int TIMEOUT        = 6,
   parameter int FIRST_BYTE_MIN = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic                         clear_i,
   input  logic                         instr_valid_i,
   input  logic [31:0]                  pc_i,
   input  logic [2:0]                   mem_op_i,
   input  logic [4:0]                   rs1_i,
   input  logic [4:0]                   rd_i,
   input  logic [31:0]                  addr_i,
   input  logic [31:0]                  wdata_i,
   output logic                         load_hit_o,
   output logic                         chain_alarm_o,
   output logic                         first_byte_alarm_o,
   output logic [31:0]                  alarm_addr_o,
   output logic [$clog2(RANGE_DEPTH):0] range_count_o,
   output logic                         drop_o
);

   localparam logic [2:0] c_OP_LB = 3'd1;
   localparam logic [2:0] c_OP_LW = 3'd2;
   localparam logic [2:0] c_OP_SB = 3'd3;
   localparam logic [2:0] c_OP_SH = 3'd4;
   localparam logic [2:0] c_OP_SW = 3'd5;
   localparam int         c_DW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int         c_PW    = $clog2(RANGE_DEPTH);
   localparam int         c_CW    = c_PW + 1;
   localparam logic [c_DW-1:0] c_DATE_INIT = c_DW'(TIMEOUT);

   // Tracker state
   logic [NUM_TRACKERS-1:0] r_active;
   logic [NUM_TRACKERS-1:0] r_pending;
   logic [31:0]             r_start     [NUM_TRACKERS];
   logic [31:0]             r_end       [NUM_TRACKERS];
   logic [31:0]             r_count     [NUM_TRACKERS];
   logic [31:0]             r_same      [NUM_TRACKERS];
   logic [31:0]             r_last_data [NUM_TRACKERS];
   logic [c_DW-1:0]         r_date      [NUM_TRACKERS];

   // Range table and its write stage
   logic [31:0]             r_tab_start [RANGE_DEPTH];
   logic [31:0]             r_tab_end   [RANGE_DEPTH];
   logic [RANGE_DEPTH-1:0]  r_tab_valid;
   logic [c_PW-1:0]         r_wr_ptr;
   logic                    r_wr_valid;
   logic [31:0]             r_wr_start;
   logic [31:0]             r_wr_end;

   logic [31:0]             r_last_pc;
   logic [4:0]              r_last_reg;

   logic                    w_accept, w_store, w_other;
   logic [31:0]             w_size, w_mask, w_new_end;
   logic [NUM_TRACKERS-1:0] w_ext_sel, w_alloc_sel, w_cmt_sel, w_qual;
   logic                    w_found_ext, w_found_free, w_found_cmt, w_drop;
   logic [31:0]             w_cmt_start, w_cmt_end;
   logic                    w_hit, w_fb, w_lookup, w_lw, w_lb, w_chain, w_fb_alarm;

   always_comb begin
      w_accept = instr_valid_i && en_i && (pc_i != r_last_pc);
      w_size   = 32'd0;
      w_mask   = 32'd0;
      case (mem_op_i)
         c_OP_SB: begin w_size = 32'd1; w_mask = 32'h0000_00FF; end
         c_OP_SH: begin w_size = 32'd2; w_mask = 32'h0000_FFFF; end
         c_OP_SW: begin w_size = 32'd4; w_mask = 32'hFFFF_FFFF; end
         default: begin end
      endcase
      // Stack- and frame-pointer based stores are never tracked
      w_store   = w_accept && (w_size != 32'd0) && (rs1_i != 5'd2) && (rs1_i != 5'd8);
      w_other   = w_accept && !w_store;
      w_new_end = addr_i + w_size - 32'd1;
   end

   // Lowest-index priority picks for extend, allocate and commit
   always_comb begin
      w_found_ext  = 1'b0;
      w_found_free = 1'b0;
      w_found_cmt  = 1'b0;
      w_ext_sel    = '0;
      w_alloc_sel  = '0;
      w_cmt_sel    = '0;
      w_qual       = '0;
      w_cmt_start  = 32'd0;
      w_cmt_end    = 32'd0;
      for (int i = 0; i < NUM_TRACKERS; i++) begin
         w_qual[i] = (r_count[i] > 32'(MIN_RUN)) && (r_same[i] < r_count[i]);
         if (!w_found_ext && w_store && r_active[i] && !r_pending[i] &&
             ((r_end[i] + 32'd1) == addr_i)) begin
            w_ext_sel[i] = 1'b1;
            w_found_ext  = 1'b1;
         end
         if (!w_found_free && !r_active[i]) begin
            w_alloc_sel[i] = 1'b1;
            w_found_free   = 1'b1;
         end
         if (!w_found_cmt && r_pending[i] && w_qual[i]) begin
            w_cmt_sel[i] = 1'b1;
            w_found_cmt  = 1'b1;
            w_cmt_start  = r_start[i];
            w_cmt_end    = r_end[i];
         end
      end
      if (!w_store || w_found_ext) begin
         w_alloc_sel = '0;
      end
      w_drop = w_store && !w_found_ext && !w_found_free;
   end

   always_comb begin
      w_hit = 1'b0;
      w_fb  = 1'b0;
      for (int j = 0; j < RANGE_DEPTH; j++) begin
         if (r_tab_valid[j] && (addr_i >= r_tab_start[j]) && (addr_i <= r_tab_end[j])) begin
            w_hit = 1'b1;
         end
         if (r_tab_valid[j] && (addr_i == r_tab_start[j]) &&
             ((r_tab_end[j] - r_tab_start[j] + 32'd1) > 32'(FIRST_BYTE_MIN))) begin
            w_fb = 1'b1;
         end
      end
      w_lookup   = w_accept && (rs1_i != 5'd2);
      w_lw       = w_lookup && (mem_op_i == c_OP_LW);
      w_lb       = w_lookup && (mem_op_i == c_OP_LB);
      w_chain    = w_lw && !w_hit && (rs1_i == r_last_reg) && load_hit_o;
      w_fb_alarm = w_lb && w_fb;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_active  <= '0;
         r_pending <= '0;
         for (int i = 0; i < NUM_TRACKERS; i++) begin
            r_start[i]     <= 32'd0;
            r_end[i]       <= 32'd0;
            r_count[i]     <= 32'd0;
            r_same[i]      <= 32'd0;
            r_last_data[i] <= 32'd0;
            r_date[i]      <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TRACKERS; i++) begin
            if (w_ext_sel[i]) begin
               r_end[i]       <= w_new_end;
               r_count[i]     <= r_count[i] + w_size;
               r_date[i]      <= c_DATE_INIT;
               r_last_data[i] <= wdata_i;
               if (((wdata_i ^ r_last_data[i]) & w_mask) == 32'd0) begin
                  r_same[i] <= r_same[i] + w_size;
               end
            end else if (w_alloc_sel[i]) begin
               r_active[i]    <= 1'b1;
               r_pending[i]   <= 1'b0;
               r_start[i]     <= addr_i;
               r_end[i]       <= w_new_end;
               r_count[i]     <= w_size;
               r_same[i]      <= w_size;
               r_date[i]      <= c_DATE_INIT;
               r_last_data[i] <= wdata_i;
            end else if (r_pending[i]) begin
               // Non-qualifying runs retire at once; qualifying ones wait their turn
               if (w_cmt_sel[i] || !w_qual[i]) begin
                  r_active[i]  <= 1'b0;
                  r_pending[i] <= 1'b0;
               end
            end else if (w_other && r_active[i]) begin
               if (r_date[i] == '0) begin
                  r_pending[i] <= 1'b1;
               end else begin
                  r_date[i] <= r_date[i] - c_DW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_tab_valid   <= '0;
         r_wr_ptr      <= '0;
         r_wr_valid    <= 1'b0;
         range_count_o <= '0;
      end else begin
         r_wr_valid <= |w_cmt_sel;
         if (r_wr_valid) begin
            r_tab_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr              <= r_wr_ptr + c_PW'(1);
            if (range_count_o != c_CW'(RANGE_DEPTH)) begin
               range_count_o <= range_count_o + c_CW'(1);
            end
         end
      end
   end

   // Table payload carries no reset; the valid bits gate every use
   always_ff @(posedge clk_i) begin
      r_wr_start <= w_cmt_start;
      r_wr_end   <= w_cmt_end;
      if (r_wr_valid) begin
         r_tab_start[r_wr_ptr] <= r_wr_start;
         r_tab_end[r_wr_ptr]   <= r_wr_end;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_last_pc          <= 32'd0;
         r_last_reg         <= 5'd0;
         load_hit_o         <= 1'b0;
         chain_alarm_o      <= 1'b0;
         first_byte_alarm_o <= 1'b0;
         alarm_addr_o       <= 32'd0;
         drop_o             <= 1'b0;
      end else begin
         drop_o <= w_drop;
         if (w_accept) begin
            r_last_pc <= pc_i;
         end
         if (w_lw) begin
            if (w_hit) begin
               load_hit_o <= 1'b1;
               r_last_reg <= rd_i;
            end else if (w_chain) begin
               chain_alarm_o <= 1'b1;
            end else begin
               load_hit_o <= 1'b0;
               r_last_reg <= 5'd0;
            end
         end
         if (w_fb_alarm) begin
            first_byte_alarm_o <= 1'b1;
         end
         if ((w_chain || w_fb_alarm) && !chain_alarm_o && !first_byte_alarm_o) begin
            alarm_addr_o <= addr_i;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bop_multi_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bop_multi_unit
//  Purpose  : Self-checking bench for bop_multi_unit against a range-list model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bop_multi_unit;
   localparam int NT  = 4;
   localparam int RD  = 8;
   localparam int MR  = 16;
   localparam int TO  = 6;
   localparam int FBM = 8;
   localparam int CW  = $clog2(RD) + 1;

   logic          clk_i = 1'b0;
   logic          rst_i, en_i, clear_i, instr_valid_i;
   logic [31:0]   pc_i, addr_i, wdata_i;
   logic [2:0]    mem_op_i;
   logic [4:0]    rs1_i, rd_i;
   logic          load_hit_o, chain_alarm_o, first_byte_alarm_o, drop_o;
   logic [31:0]   alarm_addr_o;
   logic [CW-1:0] range_count_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pc_ctr   = 32'h100;
   int          writes   = 0;

   typedef struct {
      logic [31:0] s;
      logic [31:0] e;
   } rng_t;
   rng_t tab_q[$];

   bop_multi_unit #(
      .NUM_TRACKERS(NT), .RANGE_DEPTH(RD), .MIN_RUN(MR),
      .TIMEOUT(TO), .FIRST_BYTE_MIN(FBM)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
      .instr_valid_i(instr_valid_i), .pc_i(pc_i), .mem_op_i(mem_op_i),
      .rs1_i(rs1_i), .rd_i(rd_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .load_hit_o(load_hit_o), .chain_alarm_o(chain_alarm_o),
      .first_byte_alarm_o(first_byte_alarm_o), .alarm_addr_o(alarm_addr_o),
      .range_count_o(range_count_o), .drop_o(drop_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic bit model_hit(input logic [31:0] a);
      foreach (tab_q[k]) begin
         if (tab_q[k].s <= a && a <= tab_q[k].e) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic void model_push(input logic [31:0] s, input logic [31:0] e);
      rng_t r;
      r.s = s;
      r.e = e;
      tab_q.push_back(r);
      if (tab_q.size() > RD) void'(tab_q.pop_front());
      writes++;
   endfunction

   function automatic logic [CW-1:0] model_count();
      return (writes > RD) ? CW'(RD) : CW'(writes);
   endfunction

   task automatic issue(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] wd, input bit reuse_pc);
      @(negedge clk_i);
      if (!reuse_pc) pc_ctr = pc_ctr + 32'd4;
      instr_valid_i = 1'b1;
      pc_i = pc_ctr; mem_op_i = op; rs1_i = rs1; rd_i = rd; addr_i = addr; wdata_i = wd;
      @(posedge clk_i);
      #1;
      instr_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   // Enough non-store instructions to expire any tracker, then time to commit all
   task automatic flush();
      for (int k = 0; k < TO + 1; k++) issue(3'd0, 5'd1, 5'd0, 32'h0, 32'h0, 1'b0);
      idle(NT + 4);
   endtask

   task automatic do_clear(input string tag);
      @(negedge clk_i);
      clear_i = 1'b1;
      instr_valid_i = 1'b1; pc_ctr = pc_ctr + 32'd4; pc_i = pc_ctr;
      mem_op_i = 3'd3; rs1_i = 5'd1; addr_i = 32'h9000; wdata_i = 32'h1;
      @(posedge clk_i);
      #1;
      clear_i = 1'b0; instr_valid_i = 1'b0;
      tab_q.delete();
      writes = 0;
      n_checks++;
      if ({load_hit_o, chain_alarm_o, first_byte_alarm_o, drop_o} !== 4'b0) begin
         n_fail++; $display("FAIL %s flags: got %b required 0000", tag,
                            {load_hit_o, chain_alarm_o, first_byte_alarm_o, drop_o});
      end
      n_checks++;
      if (alarm_addr_o !== 32'd0 || range_count_o !== '0) begin
         n_fail++; $display("FAIL %s addr/count: got %h/%0d required 0/0", tag, alarm_addr_o, range_count_o);
      end
   endtask

   // Store run with spec-level bookkeeping of byte count and repeated-data bytes
   task automatic run_stores(input logic [31:0] base, input logic [2:0] op, input int n,
                             input int rep, output bit qual, output logic [31:0] last_end);
      int s, count, same;
      logic [31:0] mask, prev, wd;
      s    = (op == 3'd3) ? 1 : (op == 3'd4) ? 2 : 4;
      mask = (s == 1) ? 32'hFF : (s == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      count = 0; same = 0; prev = 32'h0;
      for (int k = 0; k < n; k++) begin
         wd = $urandom;
         if (k > 0 && $urandom_range(0, 99) < rep) wd = prev;
         if (k == 0 || (wd & mask) == (prev & mask)) same += s;
         count += s;
         issue(op, 5'd1, 5'd0, base + 32'(k * s), wd, 1'b0);
         n_checks++;
         if (drop_o !== 1'b0) begin
            n_fail++; $display("FAIL run_drop: got %b required 0", drop_o);
         end
         prev = wd;
      end
      last_end = base + 32'(n * s) - 32'd1;
      qual = (count > MR) && (same < count);
      if (qual) model_push(base, last_end);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      issue(3'd3, 5'd1, 5'd0, 32'h100, 32'h5, 1'b0);
      idle(2);
      n_checks++;
      if ({load_hit_o, chain_alarm_o, first_byte_alarm_o, drop_o} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b required 0000",
                            {load_hit_o, chain_alarm_o, first_byte_alarm_o, drop_o});
      end
      n_checks++;
      if (alarm_addr_o !== 32'd0) begin
         n_fail++; $display("FAIL reset_alarm_addr: got %h required 0", alarm_addr_o);
      end
      n_checks++;
      if (range_count_o !== '0) begin
         n_fail++; $display("FAIL reset_range_count: got %0d required 0", range_count_o);
      end
      rst_i = 1'b0;
      idle(1);
   endtask

   task automatic test_basic();
      for (int i = 0; i < 20; i++) issue(3'd3, 5'd1, 5'd0, 32'h1000 + 32'(i), 32'(i + 1), 1'b0);
      for (int i = 0; i < TO; i++) issue(3'd0, 5'd1, 5'd0, 32'h0, 32'h0, 1'b0);
      idle(4);
      n_checks++;
      if (range_count_o !== '0) begin
         n_fail++; $display("FAIL basic_before_timeout: got %0d required 0", range_count_o);
      end
      issue(3'd0, 5'd1, 5'd0, 32'h0, 32'h0, 1'b0);
      idle(4);
      model_push(32'h1000, 32'h1013);
      n_checks++;
      if (range_count_o !== model_count()) begin
         n_fail++; $display("FAIL basic_count: got %0d required %0d", range_count_o, model_count());
      end
      issue(3'd2, 5'd1, 5'd5, 32'h1013, 32'h0, 1'b0);
      n_checks++;
      if (load_hit_o !== 1'b1) begin
         n_fail++; $display("FAIL basic_hit_end: got %b required 1", load_hit_o);
      end
      issue(3'd2, 5'd1, 5'd5, 32'h1014, 32'h0, 1'b0);
      n_checks++;
      if (load_hit_o !== 1'b0) begin
         n_fail++; $display("FAIL basic_miss_past_end: got %b required 0", load_hit_o);
      end
      issue(3'd2, 5'd1, 5'd5, 32'h1008, 32'h0, 1'b0);
      n_checks++;
      if (load_hit_o !== 1'b1 || chain_alarm_o !== 1'b0) begin
         n_fail++; $display("FAIL basic_hit_mid: got hit=%b chain=%b required 1/0", load_hit_o, chain_alarm_o);
      end
      issue(3'd2, 5'd5, 5'd6, 32'h5000, 32'h0, 1'b0);
      n_checks++;
      if (chain_alarm_o !== 1'b1 || alarm_addr_o !== 32'h5000) begin
         n_fail++; $display("FAIL basic_chain: got %b/%h required 1/00005000", chain_alarm_o, alarm_addr_o);
      end
      issue(3'd1, 5'd1, 5'd0, 32'h1001, 32'h0, 1'b0);
      n_checks++;
      if (first_byte_alarm_o !== 1'b0) begin
         n_fail++; $display("FAIL basic_lb_not_first: got %b required 0", first_byte_alarm_o);
      end
      issue(3'd1, 5'd1, 5'd0, 32'h1000, 32'h0, 1'b0);
      n_checks++;
      if (first_byte_alarm_o !== 1'b1 || alarm_addr_o !== 32'h5000) begin
         n_fail++; $display("FAIL basic_first_byte: got %b/%h required 1/00005000",
                            first_byte_alarm_o, alarm_addr_o);
      end
      do_clear("basic_clear");
   endtask

   task automatic test_same_data();
      for (int i = 0; i < 20; i++) issue(3'd3, 5'd1, 5'd0, 32'h2000 + 32'(i), 32'hAA, 1'b0);
      flush();
      n_checks++;
      if (range_count_o !== model_count()) begin
         n_fail++; $display("FAIL same_data_count: got %0d required %0d", range_count_o, model_count());
      end
      issue(3'd2, 5'd1, 5'd3, 32'h2005, 32'h0, 1'b0);
      n_checks++;
      if (load_hit_o !== model_hit(32'h2005)) begin
         n_fail++; $display("FAIL same_data_lookup: got %b required %b", load_hit_o, model_hit(32'h2005));
      end
   endtask

   task automatic test_drop();
      logic [31:0] prev [5];
      int          same [5];
      logic [31:0] wd;
      for (int j = 0; j < 5; j++) begin prev[j] = 32'h0; same[j] = 0; end
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 5; j++) begin
            wd = $urandom;
            if (k == 0 || wd == prev[j]) same[j] += 4;
            issue(3'd5, 5'd1, 5'd0, 32'(32'h100 * (j + 1) + 4 * k), wd, 1'b0);
            prev[j] = wd;
            n_checks++;
            if (drop_o !== (j == 4)) begin
               n_fail++; $display("FAIL drop_run%0d_store%0d: got %b required %b", j, k, drop_o, (j == 4));
            end
         end
      end
      for (int j = 0; j < 4; j++) begin
         if (20 > MR && same[j] < 20) model_push(32'(32'h100 * (j + 1)), 32'(32'h100 * (j + 1) + 19));
      end
      flush();
      n_checks++;
      if (range_count_o !== model_count()) begin
         n_fail++; $display("FAIL drop_count: got %0d required %0d", range_count_o, model_count());
      end
      do_clear("drop_clear");
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) issue(3'd3, 5'd1, 5'd0, 32'hFFFF_FFFE + 32'(i), 32'(i + 1), 1'b0);
      flush();
      n_checks++;
      if (range_count_o !== CW'(1)) begin
         n_fail++; $display("FAIL wrap_count: got %0d required 1", range_count_o);
      end
      issue(3'd1, 5'd1, 5'd0, 32'hFFFF_FFFE, 32'h0, 1'b0);
      n_checks++;
      if (first_byte_alarm_o !== 1'b1 || alarm_addr_o !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL wrap_first_byte: got %b/%h required 1/fffffffe",
                            first_byte_alarm_o, alarm_addr_o);
      end
      do_clear("wrap_clear");
   endtask

   task automatic test_dup_pc();
      for (int i = 0; i < 16; i++) issue(3'd3, 5'd1, 5'd0, 32'h3000 + 32'(i), 32'(i + 1), 1'b0);
      issue(3'd3, 5'd1, 5'd0, 32'h3010, 32'h77, 1'b1);
      flush();
      n_checks++;
      if (range_count_o !== '0) begin
         n_fail++; $display("FAIL dup_pc_count: got %0d required 0", range_count_o);
      end
   endtask

   task automatic test_mid_clear();
      for (int i = 0; i < 10; i++) issue(3'd3, 5'd1, 5'd0, 32'h7000 + 32'(i), 32'(i + 1), 1'b0);
      do_clear("mid_clear");
      for (int i = 10; i < 20; i++) issue(3'd3, 5'd1, 5'd0, 32'h7000 + 32'(i), 32'(i + 1), 1'b0);
      flush();
      n_checks++;
      if (range_count_o !== '0) begin
         n_fail++; $display("FAIL mid_clear_count: got %0d required 0", range_count_o);
      end
   endtask

   task automatic test_random_table();
      bit          qual;
      logic [31:0] lend, base, first_start, a;
      logic [2:0]  op;
      int          s, runs;
      logic [31:0] probes[$];
      do_clear("random_clear");
      first_start = 32'h0;
      runs = 0;
      while (writes <= RD && runs < 20) begin
         op   = 3'(3 + $urandom_range(0, 2));
         s    = (op == 3'd3) ? 1 : (op == 3'd4) ? 2 : 4;
         base = 32'h0010_0000 + 32'(runs * 32'h1000) + 32'(s * $urandom_range(0, 60));
         run_stores(base, op, MR / s + 1 + $urandom_range(0, 3), 20, qual, lend);
         if (writes == 1 && qual) first_start = base;
         flush();
         n_checks++;
         if (range_count_o !== model_count()) begin
            n_fail++; $display("FAIL random_count_run%0d: got %0d required %0d", runs, range_count_o, model_count());
         end
         runs++;
      end
      for (int r = 0; r < 4; r++) begin
         op = 3'(3 + $urandom_range(0, 2));
         run_stores(32'h0020_0000 + 32'(r * 32'h1000), op, $urandom_range(2, 12),
                    $urandom_range(0, 100), qual, lend);
         flush();
         n_checks++;
         if (range_count_o !== model_count()) begin
            n_fail++; $display("FAIL random_mixed_count%0d: got %0d required %0d", r, range_count_o, model_count());
         end
      end
      probes.push_back(first_start);
      foreach (tab_q[k]) begin
         probes.push_back(tab_q[k].s); probes.push_back(tab_q[k].e);
         probes.push_back(tab_q[k].e + 32'd1); probes.push_back(tab_q[k].s - 32'd1);
      end
      for (int k = 0; k < 10; k++) begin
         probes.push_back(32'h0010_0000 + 32'($urandom_range(0, 32'h13FFF)));
      end
      foreach (probes[k]) begin
         a = probes[k];
         issue(3'd2, 5'd1, 5'd3, a, 32'h0, 1'b0);
         n_checks++;
         if (load_hit_o !== model_hit(a)) begin
            n_fail++; $display("FAIL random_lookup %h: got %b required %b", a, load_hit_o, model_hit(a));
         end
      end
   endtask

   initial begin
      rst_i = 1'b1; en_i = 1'b1; clear_i = 1'b0; instr_valid_i = 1'b0;
      pc_i = 32'h0; mem_op_i = 3'd0; rs1_i = 5'd0; rd_i = 5'd0; addr_i = 32'h0; wdata_i = 32'h0;
      test_reset();
      test_basic();
      test_same_data();
      test_drop();
      test_wrap();
      test_dup_pc();
      test_mid_clear();
      test_random_table();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bop_multi_unit.md
BOP_MULTI_UNIT -- requirements
Module: bop_multi_unit

Interface
REQ-001 SHALL have parameter NUM_TRACKERS, default 4: number of concurrent store-run trackers (1..8).
REQ-002 SHALL have parameter RANGE_DEPTH, default 8: entries in the circular overflow-range table (power of two, 2..32).
REQ-003 SHALL have parameter MIN_RUN, default 16: a run qualifies only when its byte count is > MIN_RUN.
REQ-004 SHALL have parameter TIMEOUT, default 6: accepted non-store instructions a tracker survives without extension.
REQ-005 SHALL have parameter FIRST_BYTE_MIN, default 8: minimum range length, in bytes, for a first-byte alarm.
REQ-006 SHALL have one clock; reset is synchronous and active-high.
REQ-007 clk_i  input  1  clock.
REQ-008 rst_i  input  1  synchronous active-high reset.
REQ-009 en_i  input  1  tracking enable.
REQ-010 clear_i  input  1  synchronous clear; equivalent to reset.
REQ-011 instr_valid_i  input  1  decoded instruction is present.
REQ-012 pc_i  input  32  instruction PC.
REQ-013 mem_op_i  input  3  0 other, 1 LB, 2 LW, 3 SB, 4 SH, 5 SW, 6-7 other.
REQ-014 rs1_i / rd_i  input  5 each  source-base register / destination register.
REQ-015 addr_i  input  32  effective address (imm + rs1 value); wdata_i  input  32  store data.
REQ-016 load_hit_o  output  1  last checked LW fell inside a recorded range.
REQ-017 chain_alarm_o  output  1  sticky: dereference through a register loaded from a range.
REQ-018 first_byte_alarm_o  output  1  sticky: LB at the first byte of a qualifying range.
REQ-019 alarm_addr_o  output  32  addr_i of the first alarm since reset.
REQ-020 range_count_o  output  $clog2(RANGE_DEPTH)+1  valid table entries; saturates at RANGE_DEPTH.
REQ-021 drop_o  output  1  one-cycle pulse: store was untracked because no tracker was free.

Function
REQ-022 Accepted instruction = instr_valid_i & en_i & (pc_i != last_pc); last_pc SHALL update on accept only.
REQ-023 Tracked store = accepted SB/SH/SW with rs1_i not in {2,8}; size S = 1/2/4.
REQ-024 Tracker state: active, pending, start[31:0], end[31:0], count[31:0], same[31:0], date, last_data[31:0].
REQ-025 Extend: the lowest-index active, non-pending tracker with end+1 == addr_i SHALL set end = addr_i+S-1, count += S, date = TIMEOUT, and same += S if wdata_i[8S-1:0] == last_data[8S-1:0]; last_data <= wdata_i.
REQ-026 Allocate: if no tracker extends, the lowest-index free tracker SHALL load start = addr_i, end = addr_i+S-1, count = same = S, date = TIMEOUT.
REQ-027 If no tracker is free, the store SHALL be ignored and drop_o pulses for one cycle.
REQ-028 Any other accepted instruction SHALL decrement the date of every active tracker with date > 0; a tracker at date 0 becomes pending.
REQ-029 Qualify = count > MIN_RUN && same < count; a pending tracker that does not qualify SHALL free without a write.
REQ-030 At most one commit per cycle, lowest-index qualifying pending tracker first, independent of accept; table write at wr_ptr one cycle after selection; wr_ptr wraps modulo RANGE_DEPTH, overwriting the oldest entry.
REQ-031 Lookup (rs1_i != 2): hit = any valid entry with start <= addr_i <= end; same-cycle table writes are not visible.
REQ-032 LW hit: load_hit_o <= 1 and last_reg <= rd_i.
REQ-033 LW miss with rs1_i == last_reg && load_hit_o: chain_alarm_o <= 1.
REQ-034 LW miss otherwise: load_hit_o <= 0, last_reg <= 0.
REQ-035 LB with addr_i == start of a valid entry whose (end-start+1) > FIRST_BYTE_MIN SHALL set first_byte_alarm_o.
REQ-036 All outputs SHALL be registered; alarms and load_hit_o appear the cycle after the accepting edge.
REQ-037 Address arithmetic SHALL be 32-bit modulo; end+1 wrapping from 0xFFFFFFFF to 0 SHALL extend.

Reset
REQ-038 rst_i or clear_i SHALL zero all trackers, table valid bits, wr_ptr, last_pc, last_reg and every output on the next edge, including mid-run and mid-commit; clear_i takes priority over simultaneous inputs.

Verification
REQ-039 20 SB to 0x1000..0x1013 (distinct data), then 7 non-store accepts -> one entry [0x1000,0x1013]; range_count_o = 1.
REQ-040 Then LW addr 0x1008 rd = 5, followed by LW rs1 = 5 addr 0x5000 (miss) -> load_hit_o = 1, then chain_alarm_o = 1, alarm_addr_o = 0x5000.
REQ-041 20 SB of identical data 0xAA to 0x2000.. then timeout -> no entry written; range_count_o unchanged.
REQ-042 5 interleaved SW runs at 0x100, 0x200, 0x300, 0x400, 0x500 with NUM_TRACKERS = 4 -> the fifth run's first store pulses drop_o.
REQ-043 RANGE_DEPTH + 1 qualifying runs -> range_count_o = RANGE_DEPTH; the first range is overwritten and its lookup misses.
REQ-044 LB at 0x1000 after REQ-039 -> first_byte_alarm_o = 1; clear_i asserted -> all outputs 0 on the next cycle.
